// File: rtl/reg_logic_pkg.sv
// Shared types and the bitwise operation used by the reg_logic_pipe datapath.
package reg_logic_pkg;

    localparam int MODE_W = 2;
    localparam int MAX_W  = 64;

    typedef enum logic [MODE_W-1:0] {
        MODE_NAND = 2'd0,
        MODE_AND  = 2'd1,
        MODE_OR   = 2'd2,
        MODE_XOR  = 2'd3
    } logic_mode_t;

    // Operands are zero-extended to MAX_W by the caller; callers truncate the result.
    function automatic logic [MAX_W-1:0] apply_logic(
        input logic_mode_t       mode,
        input logic [MAX_W-1:0]  a,
        input logic [MAX_W-1:0]  b
    );
        logic [MAX_W-1:0] result;
        case (mode)
            MODE_NAND: result = ~(a & b);
            MODE_AND:  result = a & b;
            MODE_OR:   result = a | b;
            MODE_XOR:  result = a ^ b;
            default:   result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/reg_logic_stage.sv
// One valid/ready register slice; ready is combinational so bubbles collapse.
module reg_logic_stage #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         prevValid,
    input  logic [W-1:0] prevData,
    output logic         prevReady,
    output logic         nextValid,
    output logic [W-1:0] nextData,
    input  logic         nextReady
);

    logic         validQ;
    logic [W-1:0] dataQ;

    assign prevReady = !validQ || nextReady;
    assign nextValid = validQ;
    assign nextData  = dataQ;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            validQ <= 1'b0;
            dataQ  <= '0;
        end else if (prevReady) begin
            validQ <= prevValid;
            if (prevValid) begin
                dataQ <= prevData;
            end
        end
    end

endmodule

// File: rtl/reg_logic_pipe.sv
// Registered bitwise logic pipeline: input slice, logic op, then STAGES slices.
// Optional output ResultCount is enabled by defining REG_LOGIC_PIPE_COUNT_EN.
module reg_logic_pipe
    import reg_logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Input1,
    input  logic [WIDTH-1:0]  Input2,
    input  logic [MODE_W-1:0] Mode,
    input  logic              InValid,
    output logic              InReady,
    output logic [WIDTH-1:0]  OutputPad,
    output logic              OutValid,
    input  logic              OutReady
`ifdef REG_LOGIC_PIPE_COUNT_EN
    ,
    output logic [15:0]       ResultCount
`endif
);

    localparam int S0_W = MODE_W + 2 * WIDTH;

    logic [S0_W-1:0]  s0Data;
    logic [STAGES:0]  stageValid;
    logic [STAGES+1:0] stageReady;
    logic [WIDTH-1:0] stageData [0:STAGES];

    logic [MODE_W-1:0] s0Mode;
    logic [WIDTH-1:0]  s0A;
    logic [WIDTH-1:0]  s0B;

    assign {s0Mode, s0A, s0B} = s0Data;

    // stageData[0] is the combinational op result feeding slice S1.
    assign stageData[0] = WIDTH'(apply_logic(logic_mode_t'(s0Mode), MAX_W'(s0A), MAX_W'(s0B)));
    assign stageReady[STAGES+1] = OutReady;

    for (genvar k = 0; k <= STAGES; k++) begin : gStage
        if (k == 0) begin : gIn
            reg_logic_stage #(.W(S0_W)) uSlice (
                .Clock     (Clock),
                .Reset     (Reset),
                .prevValid (InValid),
                .prevData  ({Mode, Input1, Input2}),
                .prevReady (stageReady[0]),
                .nextValid (stageValid[0]),
                .nextData  (s0Data),
                .nextReady (stageReady[1])
            );
        end else begin : gOut
            reg_logic_stage #(.W(WIDTH)) uSlice (
                .Clock     (Clock),
                .Reset     (Reset),
                .prevValid (stageValid[k-1]),
                .prevData  (stageData[k-1]),
                .prevReady (stageReady[k]),
                .nextValid (stageValid[k]),
                .nextData  (stageData[k]),
                .nextReady (stageReady[k+1])
            );
        end
    end

    assign InReady   = stageReady[0];
    assign OutValid  = stageValid[STAGES];
    assign OutputPad = stageData[STAGES];

`ifdef REG_LOGIC_PIPE_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ResultCount <= 16'd0;
        end else if (OutValid && OutReady) begin
            ResultCount <= ResultCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_logic_pipe.sv
// Scoreboard bench for reg_logic_pipe (WIDTH=8, STAGES=3).
module tb_reg_logic_pipe;

    localparam int W  = 8;
    localparam int ST = 3;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] Input1, Input2;
    logic [1:0]   Mode;
    logic         InValid, InReady;
    logic [W-1:0] OutputPad;
    logic         OutValid, OutReady;
`ifdef REG_LOGIC_PIPE_COUNT_EN
    logic [15:0]  ResultCount;
`endif

    reg_logic_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Input1    (Input1),
        .Input2    (Input2),
        .Mode      (Mode),
        .InValid   (InValid),
        .InReady   (InReady),
        .OutputPad (OutputPad),
        .OutValid  (OutValid),
        .OutReady  (OutReady)
`ifdef REG_LOGIC_PIPE_COUNT_EN
        ,
        .ResultCount (ResultCount)
`endif
    );

    always #5 Clock = ~Clock;

    int checkCount = 0;
    int passCount  = 0;
    int inCount    = 0;
    int outCount   = 0;
    logic [W-1:0] sbQueue [$];
    logic         prevStall = 1'b0;
    logic [W-1:0] heldPad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        case (m)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Called at a negedge with inputs already driven; evaluates handshakes, then advances one cycle.
    task automatic step(input logic [W-1:0] exp);
        logic [W-1:0] e;
        #1;
        if (!Reset) begin
            if (prevStall) begin
                chk("stall_valid", 32'(OutValid), 32'd1);
                chk("stall_hold", 32'(OutputPad), 32'(heldPad));
            end
            if (OutValid && OutReady) begin
                outCount++;
                chk("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
                if (sbQueue.size() != 0) begin
                    e = sbQueue.pop_front();
                    chk("result", 32'(OutputPad), 32'(e));
                end
            end
            if (InValid && InReady) begin
                sbQueue.push_back(exp);
                inCount++;
            end
            prevStall = OutValid && !OutReady;
            heldPad   = OutputPad;
        end else begin
            prevStall = 1'b0;
        end
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        InValid = v; Mode = m; Input1 = a; Input2 = b;
    endtask

    initial begin
        logic [W-1:0] exp4 [4];
        int startOut, steps;

        Reset = 1'b1; OutReady = 1'b1;
        drive(1'b0, 2'd0, '0, '0);
        @(posedge Clock); @(posedge Clock); @(negedge Clock);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_pad", 32'(OutputPad), 32'd0);
        Reset = 1'b0;

        // Single NAND transaction: latency of 1+ST edges, then OutValid drops.
        drive(1'b1, 2'd0, 8'hF0, 8'hCC);
        step(8'h3F);
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        for (int k = 1; k <= ST; k++) begin
            chk("lat_low", 32'(OutValid), 32'd0);
            step(8'h00);
        end
        chk("lat_high", 32'(OutValid), 32'd1);
        chk("lat_pad", 32'(OutputPad), 32'h3F);
        step(8'h00);
        chk("after_low", 32'(OutValid), 32'd0);

        // Back-to-back modes at full throughput.
        exp4 = '{8'hF5, 8'h0A, 8'hAF, 8'hA5};
        startOut = outCount;
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 2'(m), 8'hAA, 8'h0F);
            step(exp4[m]);
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        for (int k = 0; k <= ST; k++) step(8'h00);
        chk("b2b_count", 32'(outCount - startOut), 32'd4);
        chk("b2b_empty", 32'(sbQueue.size()), 32'd0);

        // Fill with output stalled: capacity 1+ST.
        OutReady = 1'b0;
        startOut = inCount;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 8'(8'h11 * i), 8'(8'h3C + i));
            step(model(2'(i), 8'(8'h11 * i), 8'(8'h3C + i)));
        end
        chk("fill_accepted", 32'(inCount - startOut), 32'(ST + 1));
        chk("fill_inready", 32'(InReady), 32'd0);
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        OutReady = 1'b1;
        startOut = outCount;
        for (int i = 0; i < 8; i++) step(8'h00);
        chk("fill_drained", 32'(outCount - startOut), 32'(ST + 1));
        chk("fill_empty", 32'(sbQueue.size()), 32'd0);

        // Random traffic: 1000 accepted transactions with bounded runtime.
        startOut = inCount;
        steps = 0;
        while ((inCount - startOut) < 1000 && steps < 20000) begin
            logic [1:0] m;
            logic [W-1:0] a, b;
            m = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            drive(1'($urandom_range(0, 1)), m, a, b);
            OutReady = ($urandom_range(0, 9) < 6);
            step(model(m, a, b));
            steps++;
        end
        chk("rand_accepted", 32'(inCount - startOut), 32'd1000);
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        OutReady = 1'b1;
        steps = 0;
        while (sbQueue.size() != 0 && steps < 200) begin
            step(8'h00);
            steps++;
        end
        chk("rand_drained", 32'(sbQueue.size()), 32'd0);

        // Reset with three transactions in flight.
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 8'(i + 1), 8'h55);
            step(model(2'd3, 8'(i + 1), 8'h55));
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        Reset = 1'b1;
        step(8'h00);
        Reset = 1'b0;
        sbQueue.delete();
        chk("midrst_outvalid", 32'(OutValid), 32'd0);
        chk("midrst_inready", 32'(InReady), 32'd1);
        chk("midrst_pad", 32'(OutputPad), 32'd0);
        OutReady = 1'b1;
        startOut = outCount;
        for (int i = 0; i < 8; i++) step(8'h00);
        chk("midrst_no_stale", 32'(outCount - startOut), 32'd0);

`ifdef REG_LOGIC_PIPE_COUNT_EN
        chk("cnt_after_reset", 32'(ResultCount), 32'd0);
        OutReady = 1'b0;
        drive(1'b1, 2'd1, 8'hFF, 8'h0F);
        for (int i = 0; i < 6; i++) step(8'h0F);
        chk("cnt_stalled", 32'(ResultCount), 32'd0);
        OutReady = 1'b1;
        startOut = outCount;
        steps = 0;
        while ((outCount - startOut) < 65537 && steps < 70000) begin
            step(8'h0F);
            steps++;
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        chk("cnt_handshakes", 32'(outCount - startOut), 32'd65537);
        chk("cnt_wrapped", 32'(ResultCount), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
